// File: rtl/rns_mac3_if.sv
// Term/result handshake bundle for rns_mac3.
// The bias ports exist only when RNS_MAC_BIAS_EN is defined.
interface rns_mac3_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [4:0]       a1;
    logic [4:0]       w1;
    logic [4:0]       a2;
    logic [4:0]       w2;
    logic [5:0]       a3;
    logic [5:0]       w3;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       r1;
    logic [4:0]       r2;
    logic [5:0]       r3;
    logic [CNT_W-1:0] out_terms;
`ifdef RNS_MAC_BIAS_EN
    logic [4:0]       bias1;
    logic [4:0]       bias2;
    logic [5:0]       bias3;

    modport master (
        output in_valid, in_last, a1, w1, a2, w2, a3, w3, out_ready, bias1, bias2, bias3,
        input  in_ready, out_valid, r1, r2, r3, out_terms
    );
    modport slave (
        input  in_valid, in_last, a1, w1, a2, w2, a3, w3, out_ready, bias1, bias2, bias3,
        output in_ready, out_valid, r1, r2, r3, out_terms
    );
`else
    modport master (
        output in_valid, in_last, a1, w1, a2, w2, a3, w3, out_ready,
        input  in_ready, out_valid, r1, r2, r3, out_terms
    );
    modport slave (
        input  in_valid, in_last, a1, w1, a2, w2, a3, w3, out_ready,
        output in_ready, out_valid, r1, r2, r3, out_terms
    );
`endif
endinterface

// File: rtl/rns_mac3.sv
// Two-stage RNS multiply-accumulate over moduli {32, 31, 63}, one result triple per vector.
// Define RNS_MAC_BIAS_EN to start each accumulation from the bias ports instead of zero.
module rns_mac3 #(
    parameter int unsigned CNT_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    rns_mac3_if.slave bus
);

    logic             adv;
    logic             accept;

    logic [4:0]       p1_n;
    logic [4:0]       p2_n;
    logic [5:0]       p3_n;
    logic [9:0]       prod2;
    logic [11:0]      prod3;
    logic [5:0]       fold2_s;
    logic [4:0]       fold2_t;
    logic [6:0]       fold3_s;
    logic [5:0]       fold3_t;

    logic [4:0]       sum1;
    logic [5:0]       sum2_raw;
    logic [4:0]       sum2;
    logic [6:0]       sum3_raw;
    logic [5:0]       sum3;
    logic [CNT_W-1:0] cnt_inc;

    logic [4:0]       clr1;
    logic [4:0]       clr2;
    logic [5:0]       clr3;

    logic             s1_v_q, s1_v_d;
    logic             s1_last_q, s1_last_d;
    logic [4:0]       p1_q, p1_d;
    logic [4:0]       p2_q, p2_d;
    logic [5:0]       p3_q, p3_d;
    logic [4:0]       acc1_q, acc1_d;
    logic [4:0]       acc2_q, acc2_d;
    logic [5:0]       acc3_q, acc3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       r1_q, r1_d;
    logic [4:0]       r2_q, r2_d;
    logic [5:0]       r3_q, r3_d;
    logic [CNT_W-1:0] terms_q, terms_d;
    logic             out_valid_q, out_valid_d;
    logic             init_q, init_d;

    assign adv    = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && adv;

`ifdef RNS_MAC_BIAS_EN
    assign clr1 = bus.bias1;
    assign clr2 = (bus.bias2 == 5'd31) ? 5'd0 : bus.bias2;
    assign clr3 = (bus.bias3 == 6'd63) ? 6'd0 : bus.bias3;
`else
    assign clr1 = '0;
    assign clr2 = '0;
    assign clr3 = '0;
`endif

    // 2^k - 1 reduction: fold high half onto low half with end-around carry; all-ones is zero.
    always_comb begin
        p1_n    = bus.a1 * bus.w1;
        prod2   = 10'(bus.a2) * 10'(bus.w2);
        fold2_s = {1'b0, prod2[9:5]} + {1'b0, prod2[4:0]};
        fold2_t = fold2_s[4:0] + 5'(fold2_s[5]);
        p2_n    = (fold2_t == 5'd31) ? 5'd0 : fold2_t;
        prod3   = 12'(bus.a3) * 12'(bus.w3);
        fold3_s = {1'b0, prod3[11:6]} + {1'b0, prod3[5:0]};
        fold3_t = fold3_s[5:0] + 6'(fold3_s[6]);
        p3_n    = (fold3_t == 6'd63) ? 6'd0 : fold3_t;
    end

    always_comb begin
        sum1     = acc1_q + p1_q;
        sum2_raw = {1'b0, acc2_q} + {1'b0, p2_q};
        sum2     = (sum2_raw >= 6'd31) ? 5'(sum2_raw - 6'd31) : sum2_raw[4:0];
        sum3_raw = {1'b0, acc3_q} + {1'b0, p3_q};
        sum3     = (sum3_raw >= 7'd63) ? 6'(sum3_raw - 7'd63) : sum3_raw[5:0];
        cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_last_d   = s1_last_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        p3_d        = p3_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        acc3_d      = acc3_q;
        cnt_d       = cnt_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        terms_d     = terms_q;
        out_valid_d = out_valid_q;
        init_d      = init_q;

        if (adv) begin
            s1_v_d = accept;
            if (accept) begin
                p1_d      = p1_n;
                p2_d      = p2_n;
                p3_d      = p3_n;
                s1_last_d = bus.in_last;
            end
            // S1 is empty on the first edge after reset, so this never races an S2 update.
            if (init_q) begin
                acc1_d = clr1;
                acc2_d = clr2;
                acc3_d = clr3;
                init_d = 1'b0;
            end
            // adv with a pending result implies the result is being popped.
            if (out_valid_q) begin
                out_valid_d = 1'b0;
            end
            if (s1_v_q) begin
                if (s1_last_q) begin
                    r1_d        = sum1;
                    r2_d        = sum2;
                    r3_d        = sum3;
                    terms_d     = cnt_inc;
                    out_valid_d = 1'b1;
                    acc1_d      = clr1;
                    acc2_d      = clr2;
                    acc3_d      = clr3;
                    cnt_d       = '0;
                end else begin
                    acc1_d = sum1;
                    acc2_d = sum2;
                    acc3_d = sum3;
                    cnt_d  = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            p1_q        <= '0;
            p2_q        <= '0;
            p3_q        <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            acc3_q      <= '0;
            cnt_q       <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            terms_q     <= '0;
            out_valid_q <= 1'b0;
            init_q      <= 1'b1;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_last_q   <= s1_last_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            p3_q        <= p3_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            acc3_q      <= acc3_d;
            cnt_q       <= cnt_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            terms_q     <= terms_d;
            out_valid_q <= out_valid_d;
            init_q      <= init_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.r1        = r1_q;
    assign bus.r2        = r2_q;
    assign bus.r3        = r3_q;
    assign bus.out_terms = terms_q;

endmodule
